// File: rtl/store_buffer.sv
// In-order store buffer: holds ACU stores until the ROB retires them, then
// drains them to memory one write strobe at a time.
module store_buffer #(
  parameter int SB_DEPTH    = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 6,
  parameter int PTR_LEN     = $clog2(SB_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_enable,
  input  logic [XLEN-1:0]        alloc_address,
  input  logic [XLEN-1:0]        alloc_data,
  input  logic [1:0]             alloc_size,
  input  logic [ROB_TAG_LEN-1:0] alloc_rob_tag,
  input  logic                   commit_valid,
  input  logic [ROB_TAG_LEN-1:0] commit_rob_tag,
  input  logic                   squash,
  input  logic                   mem_busy,
  output logic                   full,
  output logic                   empty,
  output logic                   pending_stores,
  output logic                   write_mem,
  output logic [XLEN-1:0]        mem_address,
  output logic [XLEN-1:0]        mem_data,
  output logic [1:0]             mem_size
);

  localparam logic [PTR_LEN:0] DEPTH_CNT = (PTR_LEN+1)'(SB_DEPTH);

  logic [SB_DEPTH-1:0]    valid;
  logic [SB_DEPTH-1:0]    committed;
  logic [XLEN-1:0]        addr_q [SB_DEPTH];
  logic [XLEN-1:0]        data_q [SB_DEPTH];
  logic [1:0]             size_q [SB_DEPTH];
  logic [ROB_TAG_LEN-1:0] tag_q  [SB_DEPTH];

  logic [PTR_LEN-1:0] head;
  logic [PTR_LEN-1:0] tail;
  logic [PTR_LEN:0]   count;
  logic [PTR_LEN:0]   ncommit;

  logic               do_alloc;
  logic               do_commit;
  logic               do_drain;
  logic [PTR_LEN-1:0] commit_idx;
  logic [PTR_LEN:0]   alloc_inc;
  logic [PTR_LEN:0]   commit_inc;
  logic [PTR_LEN:0]   drain_dec;

  // Event decode; everything here depends only on registered state plus inputs.
  always_comb begin
    full           = (count == DEPTH_CNT);
    empty          = (count == {(PTR_LEN+1){1'b0}});
    pending_stores = !empty || write_mem;
    commit_idx     = head + ncommit[PTR_LEN-1:0];
    do_alloc       = alloc_enable && !full && !squash;
    do_commit      = commit_valid && !squash && (ncommit < count) &&
                     valid[commit_idx] && (tag_q[commit_idx] == commit_rob_tag);
    do_drain       = !write_mem && !mem_busy && (ncommit != {(PTR_LEN+1){1'b0}});
    alloc_inc      = {{PTR_LEN{1'b0}}, do_alloc};
    commit_inc     = {{PTR_LEN{1'b0}}, do_commit};
    drain_dec      = {{PTR_LEN{1'b0}}, do_drain};
  end

  // Entry storage, pointers, counters and the registered memory write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid       <= {SB_DEPTH{1'b0}};
      committed   <= {SB_DEPTH{1'b0}};
      head        <= {PTR_LEN{1'b0}};
      tail        <= {PTR_LEN{1'b0}};
      count       <= {(PTR_LEN+1){1'b0}};
      ncommit     <= {(PTR_LEN+1){1'b0}};
      write_mem   <= 1'b0;
      mem_address <= {XLEN{1'b0}};
      mem_data    <= {XLEN{1'b0}};
      mem_size    <= 2'b00;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= {XLEN{1'b0}};
        data_q[i] <= {XLEN{1'b0}};
        size_q[i] <= 2'b00;
        tag_q[i]  <= {ROB_TAG_LEN{1'b0}};
      end
    end else begin
      write_mem <= do_drain;
      if (do_drain) begin
        mem_address     <= addr_q[head];
        mem_data        <= data_q[head];
        mem_size        <= size_q[head];
        valid[head]     <= 1'b0;
        committed[head] <= 1'b0;
        head            <= head + {{(PTR_LEN-1){1'b0}}, 1'b1};
      end else begin
        head <= head;
      end

      if (squash) begin
        // Only the committed prefix survives; a same-edge drain removes its head.
        for (int i = 0; i < SB_DEPTH; i++) begin
          if (!committed[i]) begin
            valid[i] <= 1'b0;
          end else begin
            valid[i] <= valid[i] && !(do_drain && (PTR_LEN'(i) == head));
          end
        end
        tail    <= head + ncommit[PTR_LEN-1:0];
        count   <= ncommit - drain_dec;
        ncommit <= ncommit - drain_dec;
      end else begin
        if (do_alloc) begin
          valid[tail]     <= 1'b1;
          committed[tail] <= 1'b0;
          addr_q[tail]    <= alloc_address;
          data_q[tail]    <= alloc_data;
          size_q[tail]    <= alloc_size;
          tag_q[tail]     <= alloc_rob_tag;
          tail            <= tail + {{(PTR_LEN-1){1'b0}}, 1'b1};
        end else begin
          tail <= tail;
        end
        if (do_commit) begin
          committed[commit_idx] <= 1'b1;
        end else begin
          committed[commit_idx] <= committed[commit_idx] && !(do_drain && (commit_idx == head));
        end
        count   <= count + alloc_inc - drain_dec;
        ncommit <= ncommit + commit_inc - drain_dec;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;
  localparam int XLEN = 32;
  localparam int TL   = 6;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic            clock = 1'b0;
  logic            reset;
  logic            alloc_enable;
  logic [XLEN-1:0] alloc_address;
  logic [XLEN-1:0] alloc_data;
  logic [1:0]      alloc_size;
  logic [TL-1:0]   alloc_rob_tag;
  logic            commit_valid;
  logic [TL-1:0]   commit_rob_tag;
  logic            squash;
  logic            mem_busy;
  logic            full, empty, pending_stores, write_mem;
  logic [XLEN-1:0] mem_address, mem_data;
  logic [1:0]      mem_size;

  int checks = 0;
  int errors = 0;

  store_buffer #(.SB_DEPTH(4), .XLEN(XLEN), .ROB_TAG_LEN(TL)) dut (
    .clock(clock), .reset(reset),
    .alloc_enable(alloc_enable), .alloc_address(alloc_address), .alloc_data(alloc_data),
    .alloc_size(alloc_size), .alloc_rob_tag(alloc_rob_tag),
    .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
    .squash(squash), .mem_busy(mem_busy),
    .full(full), .empty(empty), .pending_stores(pending_stores), .write_mem(write_mem),
    .mem_address(mem_address), .mem_data(mem_data), .mem_size(mem_size)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_enable = 1'b0; alloc_address = 32'h0; alloc_data = 32'h0; alloc_size = 2'd0;
    alloc_rob_tag = 6'd0; commit_valid = 1'b0; commit_rob_tag = 6'd0;
    squash = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic alloc(input logic [TL-1:0] tag, input logic [31:0] a, input logic [31:0] d);
    alloc_enable = 1'b1; alloc_rob_tag = tag; alloc_address = a; alloc_data = d;
    alloc_size = SZ_WORD;
    step();
    alloc_enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (pending_stores !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending_stores); end
    checks++; if (write_mem !== 1'b0 || mem_address !== 32'h0 || mem_data !== 32'h0 || mem_size !== 2'd0)
      begin errors++; $display("FAIL reset_mem: got wm=%b a=%h d=%h s=%0d expected all 0", write_mem, mem_address, mem_data, mem_size); end
  endtask

  task automatic test_single_store();
    do_reset();
    alloc(6'd3, 32'h100, 32'hAB);
    checks++; if (pending_stores !== 1'b1 || empty !== 1'b0)
      begin errors++; $display("FAIL single_after_alloc: got pend=%b empty=%b expected 1/0", pending_stores, empty); end
    commit_valid = 1'b1; commit_rob_tag = 6'd3;
    step();
    commit_valid = 1'b0;
    checks++; if (write_mem !== 1'b0) begin errors++; $display("FAIL single_commit_edge_wm: got %b expected 0", write_mem); end
    step();
    checks++; if (write_mem !== 1'b1 || mem_address !== 32'h100 || mem_data !== 32'hAB || mem_size !== SZ_WORD)
      begin errors++; $display("FAIL single_write: got wm=%b a=%h d=%h s=%0d expected 1/100/ab/2", write_mem, mem_address, mem_data, mem_size); end
    checks++; if (empty !== 1'b1 || pending_stores !== 1'b1)
      begin errors++; $display("FAIL single_write_flags: got empty=%b pend=%b expected 1/1", empty, pending_stores); end
    step();
    checks++; if (write_mem !== 1'b0 || pending_stores !== 1'b0 || mem_address !== 32'h100)
      begin errors++; $display("FAIL single_after: got wm=%b pend=%b a=%h expected 0/0/100", write_mem, pending_stores, mem_address); end
  endtask

  task automatic test_fill_and_drain();
    logic [31:0] exp_addr [4];
    int n;
    logic prev_wm;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h10 * (i + 1);
      alloc(TL'(i + 1), exp_addr[i], 32'hD0 + i);
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    alloc(6'd5, 32'h500, 32'h55);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_after_drop: got %b expected 1", full); end
    n = 0;
    prev_wm = 1'b0;
    for (int c = 0; c < 16; c++) begin
      commit_valid = (c < 4);
      commit_rob_tag = TL'(c + 1);
      step();
      if (write_mem === 1'b1) begin
        checks++; if (prev_wm === 1'b1) begin errors++; $display("FAIL fill_b2b: got back-to-back strobe at cycle %0d expected gap", c); end
        checks++; if (n >= 4 || mem_address !== exp_addr[n % 4])
          begin errors++; $display("FAIL fill_order: got a=%h (pulse %0d) expected %h", mem_address, n, exp_addr[n % 4]); end
        n++;
      end
      prev_wm = write_mem;
    end
    commit_valid = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL fill_pulses: got %0d expected 4", n); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL fill_end: got empty=%b full=%b expected 1/0", empty, full); end
  endtask

  task automatic test_alloc_full_during_drain();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(TL'(i + 1), 32'h40 + i, 32'h0);
    commit_valid = 1'b1; commit_rob_tag = 6'd1;
    step();
    commit_valid = 1'b0;
    alloc_size = SZ_BYTE;
    alloc_enable = 1'b1; alloc_rob_tag = 6'd9; alloc_address = 32'h900;
    step();
    alloc_enable = 1'b0;
    checks++; if (write_mem !== 1'b1 || mem_address !== 32'h40)
      begin errors++; $display("FAIL fulldrain_write: got wm=%b a=%h expected 1/40", write_mem, mem_address); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fulldrain_dropped: got full=%b expected 0", full); end
  endtask

  task automatic test_squash_commit_same_edge();
    int wm;
    do_reset();
    alloc(6'd5, 32'h500, 32'h5);
    alloc(6'd6, 32'h600, 32'h6);
    commit_valid = 1'b1; commit_rob_tag = 6'd5; squash = 1'b1;
    step();
    commit_valid = 1'b0; squash = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sqc_empty: got %b expected 1", empty); end
    wm = 0;
    for (int c = 0; c < 5; c++) begin step(); if (write_mem === 1'b1) wm++; end
    checks++; if (wm !== 0) begin errors++; $display("FAIL sqc_nowrite: got %0d writes expected 0", wm); end
  endtask

  task automatic test_squash_keeps_committed();
    int wm;
    do_reset();
    mem_busy = 1'b1;
    alloc(6'd2, 32'h200, 32'h22);
    alloc(6'd3, 32'h300, 32'h33);
    alloc(6'd4, 32'h400, 32'h44);
    commit_valid = 1'b1; commit_rob_tag = 6'd2;
    step();
    commit_valid = 1'b0; squash = 1'b1;
    step();
    squash = 1'b0;
    checks++; if (empty !== 1'b0 || full !== 1'b0 || write_mem !== 1'b0)
      begin errors++; $display("FAIL sqk_state: got empty=%b full=%b wm=%b expected 0/0/0", empty, full, write_mem); end
    step();
    mem_busy = 1'b0;
    step();
    checks++; if (write_mem !== 1'b1 || mem_address !== 32'h200 || mem_data !== 32'h22)
      begin errors++; $display("FAIL sqk_write: got wm=%b a=%h d=%h expected 1/200/22", write_mem, mem_address, mem_data); end
    wm = 0;
    for (int c = 0; c < 6; c++) begin step(); if (write_mem === 1'b1) wm++; end
    checks++; if (wm !== 0 || empty !== 1'b1)
      begin errors++; $display("FAIL sqk_rest: got writes=%0d empty=%b expected 0/1", wm, empty); end
  endtask

  task automatic test_mem_busy();
    int wm;
    do_reset();
    mem_busy = 1'b1;
    alloc(6'd11, 32'hA0, 32'h1);
    alloc(6'd12, 32'hB0, 32'h2);
    commit_valid = 1'b1; commit_rob_tag = 6'd11; step();
    commit_rob_tag = 6'd12; step();
    commit_valid = 1'b0;
    wm = 0;
    for (int c = 0; c < 10; c++) begin step(); if (write_mem === 1'b1) wm++; end
    checks++; if (wm !== 0) begin errors++; $display("FAIL busy_hold: got %0d writes expected 0", wm); end
    mem_busy = 1'b0;
    step();
    checks++; if (write_mem !== 1'b1 || mem_address !== 32'hA0)
      begin errors++; $display("FAIL busy_first: got wm=%b a=%h expected 1/a0", write_mem, mem_address); end
    step();
    checks++; if (write_mem !== 1'b0 || mem_address !== 32'hA0)
      begin errors++; $display("FAIL busy_gap: got wm=%b a=%h expected 0/a0", write_mem, mem_address); end
    step();
    checks++; if (write_mem !== 1'b1 || mem_address !== 32'hB0)
      begin errors++; $display("FAIL busy_second: got wm=%b a=%h expected 1/b0", write_mem, mem_address); end
  endtask

  task automatic test_tag_mismatch_and_reset();
    int wm;
    do_reset();
    alloc(6'd7, 32'h700, 32'h7);
    alloc(6'd8, 32'h800, 32'h8);
    alloc(6'd10, 32'hA00, 32'hA);
    commit_valid = 1'b1; commit_rob_tag = 6'd9;
    step();
    commit_valid = 1'b0;
    wm = 0;
    for (int c = 0; c < 4; c++) begin step(); if (write_mem === 1'b1) wm++; end
    checks++; if (wm !== 0) begin errors++; $display("FAIL mismatch_ignored: got %0d writes expected 0", wm); end
    mem_busy = 1'b1;
    commit_valid = 1'b1; commit_rob_tag = 6'd7;
    step();
    commit_valid = 1'b0; mem_busy = 1'b0; reset = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || write_mem !== 1'b0 || pending_stores !== 1'b0 || mem_address !== 32'h0)
      begin errors++; $display("FAIL midreset: got empty=%b wm=%b pend=%b a=%h expected 1/0/0/0", empty, write_mem, pending_stores, mem_address); end
    reset = 1'b1;
    wm = 0;
    for (int c = 0; c < 4; c++) begin step(); if (write_mem === 1'b1) wm++; end
    checks++; if (wm !== 0) begin errors++; $display("FAIL midreset_nowrite: got %0d writes expected 0", wm); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_single_store();
    test_fill_and_drain();
    test_alloc_full_during_drain();
    test_squash_commit_same_edge();
    test_squash_keeps_committed();
    test_mem_busy();
    test_tag_mismatch_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
